// File: rtl/shared_pkg.sv
// Shared read-side FIFO parameters and the read controller state encoding.
package shared_pkg;

   localparam int FIFO_WIDTH = 16;
   localparam int FIFO_DEPTH = 16;
   localparam int STAT_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: issues reads, absorbs the 1-cycle read latency in a 2-entry
// skid buffer and presents a valid/ready stream. Define RD_CTRL_STATS_EN for rd_count.
module fifo_rd_ctrl #(
   parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
   parameter int STAT_W     = shared_pkg::STAT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  m_valid,
   output logic [FIFO_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  err_underflow,
   output logic [STAT_W-1:0]     rd_count,
   output logic [1:0]            dbg_state,
   output logic [1:0]            dbg_occ
);
   import shared_pkg::*;

   // Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
   // m_valid never depends on m_ready, and m_data holds while m_valid && !m_ready.

   rd_state_e             state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic                  wr_ptr_q, rd_ptr_q;
   logic                  err_q;
   logic [FIFO_WIDTH-1:0] mem_q [2];
   logic                  push, pop;
   logic [2:0]            occ_proj;

   assign push     = inflight_q;
   assign m_valid  = (occ_q != 2'd0) && !rst;
   assign pop      = m_valid && m_ready;
   assign m_data   = mem_q[rd_ptr_q];
   // Projected occupancy once the outstanding read lands; keeps the buffer from overflowing.
   assign occ_proj = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   assign fifo_rd_en = enable && (state_q == RUN) && !fifo_empty && !rst
                       && (occ_proj < 3'd2);

   assign busy          = (state_q != IDLE) || (occ_q != 2'd0);
   assign err_underflow = err_q;
   assign dbg_state     = state_q;
   assign dbg_occ       = occ_q;

   always_comb begin
      occ_d = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + 2'd1;
      end else if (!push && pop) begin
         occ_d = occ_q - 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = DRAIN;
         DRAIN: begin
            if (enable) begin
               state_d = RUN;
            end else if (!inflight_q && (occ_q == 2'd0)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         if (fifo_underflow) err_q <= 1'b1;
      end
   end

   // Data storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= fifo_data_out;
      end
   end

`ifdef RD_CTRL_STATS_EN
   logic [STAT_W-1:0] rd_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q <= '0;
      end else if (pop) begin
         rd_count_q <= rd_count_q + 1'b1;
      end
   end

   assign rd_count = rd_count_q;
`else
   assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural read-side FIFO and an in-order scoreboard.
module tb_fifo_rd_ctrl;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
`ifdef RD_CTRL_STATS_EN
   localparam int STATS_ON = 1;
`else
   localparam int STATS_ON = 0;
`endif

   logic        clk;
   logic        rst;
   logic        enable;
   logic        fifo_rd_en;
   logic [15:0] fifo_data_out;
   logic        fifo_empty;
   logic        fifo_underflow;
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_ready;
   logic        busy;
   logic        err_underflow;
   logic [15:0] rd_count;
   logic [1:0]  dbg_state;
   logic [1:0]  dbg_occ;

   // behavioural FIFO
   logic [15:0] fifo_mem [0:15];
   logic [3:0]  fifo_wp, fifo_rp;
   logic [4:0]  fifo_cnt;
   logic        push_req, fifo_flush;
   logic [15:0] push_data;

   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_rd     = 0;
   int          n_pop    = 0;
   logic        hold_pending = 1'b0;
   logic [15:0] hold_data    = 16'h0;

   fifo_rd_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .m_valid        (m_valid),
      .m_data         (m_data),
      .m_ready        (m_ready),
      .busy           (busy),
      .err_underflow  (err_underflow),
      .rd_count       (rd_count),
      .dbg_state      (dbg_state),
      .dbg_occ        (dbg_occ)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign fifo_empty = (fifo_cnt == 5'd0);

   always @(posedge clk) begin
      if (fifo_flush) begin
         fifo_wp  <= 4'd0;
         fifo_rp  <= 4'd0;
         fifo_cnt <= 5'd0;
      end else begin
         if (push_req) begin
            fifo_mem[fifo_wp] <= push_data;
            fifo_wp           <= fifo_wp + 4'd1;
         end
         if (fifo_rd_en) begin
            fifo_data_out <= fifo_mem[fifo_rp];
            fifo_rp       <= fifo_rp + 4'd1;
         end
         fifo_cnt <= fifo_cnt + {4'b0, push_req} - {4'b0, fifo_rd_en};
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Monitor samples 1 ns before each rising edge, when inputs and outputs are settled.
   always begin
      @(negedge clk);
      #4;
      if (rst) begin
         check("valid_in_rst", {31'b0, m_valid}, 32'd0);
         check("rd_en_in_rst", {31'b0, fifo_rd_en}, 32'd0);
         exp_q.delete();
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) check("hold_data", {16'b0, m_data}, {16'b0, hold_data});
         hold_pending = m_valid && !m_ready;
         hold_data    = m_data;
         if (m_valid && m_ready) begin
            n_pop++;
            if (exp_q.size() == 0) check("sb_extra_word", 32'd1, 32'd0);
            else check("sb_data", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
         end
         if (fifo_rd_en) begin
            n_rd++;
            check("rd_nonempty", {31'b0, fifo_empty}, 32'd0);
            exp_q.push_back(fifo_mem[fifo_rp]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0; fifo_flush = 1'b1;
      tick(2);
      rst = 1'b0; fifo_flush = 1'b0;
   endtask

   task automatic load(input logic [15:0] w);
      push_req = 1'b1; push_data = w;
      tick(1);
      push_req = 1'b0;
   endtask

   initial begin
      int base_rd, base_pop;
      logic seen;
      rst = 1'b1; enable = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
      push_req = 1'b0; push_data = 16'h0; fifo_flush = 1'b1;

      // reset state
      tick(1);
      check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      check("rst_valid", {31'b0, m_valid}, 32'd0);
      do_reset();
      check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      check("rst_occ", {30'b0, dbg_occ}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_err", {31'b0, err_underflow}, 32'd0);
      check("rst_count", {16'b0, rd_count}, 32'd0);

      // streaming at full rate
      for (int i = 1; i <= 8; i++) load(16'(i));
      enable = 1'b1; m_ready = 1'b1;
      base_rd = n_rd;
      for (int i = 1; i <= 12; i++) begin
         tick(1);
         check("s1_rd_en", {31'b0, fifo_rd_en}, (i <= 8) ? 32'd1 : 32'd0);
         if (i >= 3 && i <= 10) begin
            check("s1_valid", {31'b0, m_valid}, 32'd1);
            check("s1_data", {16'b0, m_data}, 32'(i - 2));
         end
      end
      check("s1_valid_end", {31'b0, m_valid}, 32'd0);
      check("s1_reads", 32'(n_rd - base_rd), 32'd8);
      check("s1_count", {16'b0, rd_count}, 32'(8 * STATS_ON));

      // backpressure fills the buffer, then resumes in order
      do_reset();
      for (int i = 1; i <= 5; i++) load(16'h0010 + 16'(i));
      enable = 1'b1; m_ready = 1'b0;
      base_rd = n_rd; base_pop = n_pop;
      tick(1); check("s2_rd1", {31'b0, fifo_rd_en}, 32'd1);
      tick(1); check("s2_rd2", {31'b0, fifo_rd_en}, 32'd1);
      tick(1); check("s2_rd3", {31'b0, fifo_rd_en}, 32'd0);
      check("s2_occ1", {30'b0, dbg_occ}, 32'd1);
      check("s2_data1", {16'b0, m_data}, 32'h11);
      tick(5);
      check("s2_occ2", {30'b0, dbg_occ}, 32'd2);
      check("s2_rd_hold", {31'b0, fifo_rd_en}, 32'd0);
      check("s2_data_held", {16'b0, m_data}, 32'h11);
      check("s2_reads", 32'(n_rd - base_rd), 32'd2);
      m_ready = 1'b1;
      tick(12);
      check("s2_valid_end", {31'b0, m_valid}, 32'd0);
      check("s2_pops", 32'(n_pop - base_pop), 32'd5);
      check("s2_sb_empty", 32'(exp_q.size()), 32'd0);
      check("s2_count", {16'b0, rd_count}, 32'(5 * STATS_ON));

      // empty FIFO: never read
      do_reset();
      enable = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         tick(1);
         if (fifo_rd_en) seen = 1'b1;
      end
      check("s3_no_rd", {31'b0, seen}, 32'd0);
      check("s3_err", {31'b0, err_underflow}, 32'd0);
      check("s3_valid", {31'b0, m_valid}, 32'd0);
      check("s3_state", {30'b0, dbg_state}, {30'b0, ST_RUN});
      check("s3_busy", {31'b0, busy}, 32'd1);

      // enable dropped with a read outstanding
      do_reset();
      for (int i = 1; i <= 3; i++) load(16'h0020 + 16'(i));
      enable = 1'b1; m_ready = 1'b1;
      base_rd = n_rd; base_pop = n_pop;
      tick(1); check("s4_rd", {31'b0, fifo_rd_en}, 32'd1);
      tick(1); enable = 1'b0;
      tick(1);
      check("s4_state_drain", {30'b0, dbg_state}, {30'b0, ST_DRAIN});
      check("s4_rd_off", {31'b0, fifo_rd_en}, 32'd0);
      check("s4_valid", {31'b0, m_valid}, 32'd1);
      check("s4_data", {16'b0, m_data}, 32'h21);
      tick(1);
      check("s4_still_drain", {30'b0, dbg_state}, {30'b0, ST_DRAIN});
      check("s4_busy_drain", {31'b0, busy}, 32'd1);
      check("s4_occ0", {30'b0, dbg_occ}, 32'd0);
      tick(1);
      check("s4_state_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      check("s4_busy_low", {31'b0, busy}, 32'd0);
      check("s4_reads", 32'(n_rd - base_rd), 32'd1);
      check("s4_pops", 32'(n_pop - base_pop), 32'd1);
      check("s4_fifo_left", {27'b0, fifo_cnt}, 32'd2);

      // reset mid-transfer (buffer holding a word, next read in flight)
      load(16'h0031); load(16'h0032);
      enable = 1'b1; m_ready = 1'b0;
      tick(3);
      check("s5_occ_pre", {30'b0, dbg_occ}, 32'd1);
      check("s5_data_pre", {16'b0, m_data}, 32'h22);
      check("s5_count_pre", {16'b0, rd_count}, 32'(STATS_ON));
      rst = 1'b1; enable = 1'b0;
      #1;
      check("s5_valid_rst", {31'b0, m_valid}, 32'd0);
      tick(1);
      rst = 1'b0;
      #1;
      check("s5_valid", {31'b0, m_valid}, 32'd0);
      check("s5_occ", {30'b0, dbg_occ}, 32'd0);
      check("s5_count", {16'b0, rd_count}, 32'd0);
      check("s5_err", {31'b0, err_underflow}, 32'd0);
      check("s5_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      tick(2);
      check("s5_no_late_push", {30'b0, dbg_occ}, 32'd0);
      check("s5_valid_late", {31'b0, m_valid}, 32'd0);

      // sticky underflow error
      check("s6_err_pre", {31'b0, err_underflow}, 32'd0);
      fifo_underflow = 1'b1;
      tick(1);
      fifo_underflow = 1'b0;
      check("s6_err_set", {31'b0, err_underflow}, 32'd1);
      tick(5);
      check("s6_err_held", {31'b0, err_underflow}, 32'd1);
      do_reset();
      check("s6_err_clr", {31'b0, err_underflow}, 32'd0);

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
